// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmit path.
//   uart_tx_state_e  : transmitter FSM states
//   UART_DATA_BITS   : data bits per frame
//   UART_IDLE_LEVEL  : line level while no frame is on the wire
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write wdata on the edge where push=1 and not full
//   pop/rdata  : rdata shows the head entry; pop=1 and not empty discards it
//   full/empty : occupancy flags
//   level      : number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so a full FIFO (same address, different
// wrap bit) is distinguishable from an empty one (pointers identical).
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity,
// one stop bit, with a small input FIFO.
//   clk, rst         : clock, asynchronous active-high reset
//   tx_data_i        : byte to send
//   tx_valid_i       : tx_data_i valid
//   tx_ready_o       : FIFO not full
//   cfg_div_i        : clock cycles per bit (0 behaves as 1)
//   cfg_parity_en_i  : 1 = append an even-parity bit
//   tx_o             : serial line, idles high
//   busy_o           : frame in progress or bytes waiting
//   fifo_level_o     : FIFO occupancy
//
// Handshake: a byte is accepted on every rising clk edge where tx_valid_i and
// tx_ready_o are both 1; tx_ready_o does not depend on tx_valid_i, and the
// source must hold tx_data_i stable while tx_valid_i is high and not accepted.
module uart_tx_8n1
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   input  logic [DIV_WIDTH-1:0]          cfg_div_i,
   input  logic                          cfg_parity_en_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   uart_tx_state_e       state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 par_en_q, par_en_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [7:0]           fifo_rdata;
   logic                 push;
   logic                 pop;
   logic                 tick;
   logic [DIV_WIDTH-1:0] eff_div;
   logic [LW-1:0]        level_d;

   assign tx_ready_o = !fifo_full;
   assign push       = tx_valid_i && !fifo_full;
   // The FSM takes the head byte on the edge it leaves IDLE.
   assign pop        = (state_q == IDLE) && !fifo_empty;
   assign eff_div    = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
   assign tick       = (cnt_q == '0);
   assign level_d    = fifo_level_o + LW'(push) - LW'(pop);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (tx_data_i),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         div_q     <= DIV_WIDTH'(1);
         par_en_q  <= 1'b0;
         parity_q  <= 1'b0;
         tx_q      <= UART_IDLE_LEVEL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         par_en_q  <= par_en_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      par_en_d  = par_en_q;
      parity_d  = parity_q;
      tx_d      = UART_IDLE_LEVEL;
      busy_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Configuration is sampled only here, so it is fixed per frame.
            if (!fifo_empty) begin
               shift_d  = fifo_rdata;
               parity_d = ^fifo_rdata;
               div_d    = eff_div;
               par_en_d = cfg_parity_en_i;
               cnt_d    = eff_div - DIV_WIDTH'(1);
               state_d  = START;
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               cnt_d     = div_q - DIV_WIDTH'(1);
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d = div_q - DIV_WIDTH'(1);
               if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               cnt_d   = div_q - DIV_WIDTH'(1);
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level and busy are registered from the next state so the pad
      // sees a glitch-free signal with no extra cycle of latency.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d;
         default: tx_d = UART_IDLE_LEVEL;
      endcase

      busy_d = (state_d != IDLE) || (level_d != '0);
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
module tb_uart_tx_8n1;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [15:0] cfg_div_i;
   logic        cfg_parity_en_i;
   logic        tx_o;
   logic        busy_o;
   logic [2:0]  fifo_level_o;

   uart_tx_8n1 #(
      .FIFO_DEPTH (4),
      .DIV_WIDTH  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tx_data_i       (tx_data_i),
      .tx_valid_i      (tx_valid_i),
      .tx_ready_o      (tx_ready_o),
      .cfg_div_i       (cfg_div_i),
      .cfg_parity_en_i (cfg_parity_en_i),
      .tx_o            (tx_o),
      .busy_o          (busy_o),
      .fifo_level_o    (fifo_level_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   // entry = {parity_en, effective_div[15:0], data[7:0]}
   logic [24:0] exp_q[$];
   int          gap_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          frames_done = 0;
   logic        mon_busy = 1'b0;
   logic        last_pbit;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_byte(input logic [7:0] d);
      int guard;
      logic [15:0] ed;
      guard = 0;
      tx_data_i  = d;
      tx_valid_i = 1'b1;
      while (!tx_ready_o && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      check("push_ready_timeout", guard >= 2000, 0);
      ed = (cfg_div_i == 16'd0) ? 16'd1 : cfg_div_i;
      exp_q.push_back({cfg_parity_en_i, ed, d});
      @(posedge clk); #1;
      tx_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy_o !== 1'b0 || mon_busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", n >= budget, 0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- line monitor (receiver model) ----------------
   initial begin : monitor
      logic [24:0] e;
      logic [7:0]  d;
      logic [7:0]  rx;
      int          dv;
      logic        pe;
      int          nb;
      int          bad;
      int          idle_run;
      int          frame_no;
      logic        aborted;
      logic        exp_bits [11];
      idle_run = 0;
      frame_no = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            idle_run = 0;
         end else if (tx_o !== 1'b0) begin
            idle_run++;
         end else if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            while (tx_o === 1'b0 && !rst) @(negedge clk);
            idle_run = 0;
         end else begin
            mon_busy = 1'b1;
            e  = exp_q.pop_front();
            d  = e[7:0];
            dv = int'(e[23:8]);
            pe = e[24];
            gap_q.push_back(idle_run);
            nb = pe ? 11 : 10;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
            exp_bits[9]    = ^d;
            exp_bits[nb-1] = 1'b1;
            aborted = 1'b0;
            rx = '0;
            for (int b = 0; b < nb && !aborted; b++) begin
               bad = 0;
               for (int s = 0; s < dv; s++) begin
                  if (!(b == 0 && s == 0)) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_o !== exp_bits[b]) bad++;
                  if (s == dv / 2 && b >= 1 && b <= 8) rx[b-1] = tx_o;
                  if (s == dv / 2 && pe && b == 9) last_pbit = tx_o;
               end
               if (!aborted) check($sformatf("frame%0d_bit%0d", frame_no, b), bad, 0);
            end
            if (!aborted) begin
               check($sformatf("frame%0d_rx_byte", frame_no), rx, d);
               frames_done++;
            end
            frame_no++;
            idle_run = 0;
            mon_busy = 1'b0;
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  data;
      logic [15:0] div;
      logic        par;
      int          len;   // cycles from tx_o falling to busy_o dropping
      logic        pbit;  // expected parity bit when par=1
   } vec_t;

   vec_t tbl [6];

   initial begin : main
      int          n;
      int          m;
      int          f0;
      int          exp_lv  [5];
      logic        exp_rdy [5];

      tbl[0] = '{8'h65, 16'd32, 1'b0, 320, 1'b0};
      tbl[1] = '{8'h07, 16'd4,  1'b1, 44,  1'b1};
      tbl[2] = '{8'hA5, 16'd0,  1'b0, 10,  1'b0};
      tbl[3] = '{8'hFF, 16'd3,  1'b1, 33,  1'b0};
      tbl[4] = '{8'h00, 16'd1,  1'b1, 11,  1'b0};
      tbl[5] = '{8'h80, 16'd2,  1'b1, 22,  1'b1};
      exp_lv  = '{1, 1, 2, 3, 4};
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst             = 1'b1;
      tx_data_i       = 8'h00;
      tx_valid_i      = 1'b0;
      cfg_div_i       = 16'd32;
      cfg_parity_en_i = 1'b0;

      cycles(2);
      check("rst_tx", tx_o, 1);
      check("rst_ready", tx_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_level", fifo_level_o, 0);
      rst = 1'b0;
      cycles(2);
      check("post_rst_tx", tx_o, 1);

      // Table-driven single frames.
      for (int i = 0; i < 6; i++) begin
         cfg_div_i       = tbl[i].div;
         cfg_parity_en_i = tbl[i].par;
         last_pbit       = 1'bx;
         push_byte(tbl[i].data);
         check($sformatf("v%0d_busy_after_push", i), busy_o, 1);
         n = 0;
         while (tx_o !== 1'b0 && n < 8) begin
            @(posedge clk); #1;
            n++;
         end
         check($sformatf("v%0d_start_latency", i), n, 1);
         m = 0;
         while (busy_o !== 1'b0 && m < 2000) begin
            @(posedge clk); #1;
            m++;
         end
         check($sformatf("v%0d_frame_len", i), m, tbl[i].len);
         if (tbl[i].par) check($sformatf("v%0d_parity_bit", i), last_pbit, tbl[i].pbit);
         check($sformatf("v%0d_tx_idle", i), tx_o, 1);
         cycles(2);
      end

      // Back-to-back burst: fills FIFO plus shift register, wraps pointers,
      // and the second push coincides with the first pop.
      cfg_div_i       = 16'd2;
      cfg_parity_en_i = 1'b0;
      gap_q.delete();
      f0 = frames_done;
      for (int i = 0; i < 5; i++) begin
         push_byte(8'($urandom_range(0, 255)));
         check($sformatf("burst%0d_level", i), fifo_level_o, exp_lv[i]);
         check($sformatf("burst%0d_ready", i), tx_ready_o, exp_rdy[i]);
      end
      wait_idle(1000);
      check("burst_frames", frames_done - f0, 5);
      check("burst_gap_count", gap_q.size(), 5);
      for (int i = 1; i < gap_q.size(); i++)
         check($sformatf("burst_gap%0d", i), gap_q[i], 1);
      check("burst_level_end", fifo_level_o, 0);

      // Config change mid-frame: first frame keeps div 8 / no parity,
      // queued frame picks up div 5 / parity.
      cfg_div_i       = 16'd8;
      cfg_parity_en_i = 1'b0;
      f0 = frames_done;
      push_byte(8'($urandom_range(0, 255)));
      cycles(10);
      cfg_div_i       = 16'd5;
      cfg_parity_en_i = 1'b1;
      push_byte(8'($urandom_range(0, 255)));
      wait_idle(1000);
      check("cfgchg_frames", frames_done - f0, 2);

      // Reset during DATA with a byte still queued.
      cfg_div_i       = 16'd16;
      cfg_parity_en_i = 1'b0;
      push_byte(8'hC3);
      cycles(36);
      push_byte(8'h3C);
      check("midrst_level_before", fifo_level_o, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_tx", tx_o, 1);
      check("midrst_level", fifo_level_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_ready", tx_ready_o, 1);
      exp_q.delete();
      cycles(2);
      rst = 1'b0;
      cycles(2);
      check("after_rst_tx", tx_o, 1);
      cfg_div_i = 16'd4;
      f0 = frames_done;
      push_byte(8'h5A);
      wait_idle(500);
      check("after_rst_frames", frames_done - f0, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
